prog_counter_ctrl: RTL and testbench

//  Command sequencer directly upstream of the 8-bit programmable counter: drives its load, enable,
//  up_down, load_value and max_count, and watches its tc/zero flags.
//  - Accepts one count job per valid/ready handshake: start value, limit and direction.
//  - Loads the counter, enables it until the direction-specific terminal flag is seen, then reports done.

---
 rtl/prog_counter_ctrl_pkg.sv | 13 +
 rtl/prog_counter_ctrl_watchdog.sv | 23 ++
 rtl/prog_counter_ctrl.sv | 99 +++++++++
 tb/tb_prog_counter_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_ctrl_pkg.sv
// prog_counter_pkg: shared state encoding, command record and data width for the
// programmable-counter command sequencer.
package prog_counter_pkg;
    localparam int PCC_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} pcc_state_e;

    typedef struct packed {
        logic [PCC_W-1:0] value;
        logic [PCC_W-1:0] max;
        logic             up;
    } pcc_cmd_t;
endpackage

// File: rtl/prog_counter_ctrl_watchdog.sv
// pcc_watchdog: counts consecutive RUN cycles (pause included) and flags the
// TIMEOUT-th one; the count restarts whenever run drops.
module pcc_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !run)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/prog_counter_ctrl.sv
// prog_counter_ctrl: accepts one count job per handshake, loads and enables the
// counter until its terminal flag, then pulses done. Optional watchdog: PCC_TIMEOUT_EN.
module prog_counter_ctrl
    import prog_counter_pkg::*;
#(
    parameter int W       = PCC_W,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_value,
    input  logic [W-1:0] cmd_max,
    input  logic         cmd_up,
    input  logic         pause,
    input  logic         abort,
    input  logic         cnt_tc,
    input  logic         cnt_zero,
`ifdef PCC_TIMEOUT_EN
    output logic         timeout_err,
`endif
    output logic         cnt_load,
    output logic         cnt_enable,
    output logic         cnt_up_down,
    output logic [W-1:0] cnt_load_val,
    output logic [W-1:0] cnt_max,
    output logic         busy,
    output logic         done,
    output logic         aborted
);
    if (W != PCC_W || TIMEOUT < 2) begin : g_bad_cfg
        $error("prog_counter_ctrl: W must equal PCC_W and TIMEOUT must be at least 2");
    end

    pcc_state_e state, state_n;
    pcc_cmd_t   cmd_q;
    logic       accept, term, kill, expire;

    assign accept       = cmd_valid && cmd_ready;
    assign term         = cmd_q.up ? cnt_tc : cnt_zero;
    assign kill         = abort || expire;
    assign cmd_ready    = rst_n && (state == IDLE);
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign cnt_load_val = cmd_q.value;
    assign cnt_max      = cmd_q.max;
    assign cnt_up_down  = cmd_q.up;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd_q   <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= state_n;
            aborted <= (state == LOAD || state == RUN) && kill;
            if (accept)
                cmd_q <= '{value: cmd_value, max: cmd_max, up: cmd_up};
        end
    end

    // Enable is combinational on the flags so the counter stops exactly on the terminal value.
    always_comb begin
        state_n    = state;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            IDLE: state_n = accept ? LOAD : IDLE;
            LOAD: begin
                state_n  = kill ? IDLE : RUN;
                cnt_load = !kill;
            end
            RUN: begin
                state_n    = kill ? IDLE : (term ? DONE : RUN);
                cnt_enable = !pause && !term && !kill;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef PCC_TIMEOUT_EN
    pcc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == RUN),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || accept)
            timeout_err <= 1'b0;
        else if (state == RUN && expire)
            timeout_err <= 1'b1;
    end
`else
    assign expire = 1'b0;
`endif
endmodule

// File: tb/tb_prog_counter_ctrl.sv
// tb_prog_counter_ctrl: directed checks of the sequencer driving a behavioural
// 8-bit up/down counter; add the PCC_TIMEOUT_EN define to also exercise the watchdog.
module tb_prog_counter_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_up = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [7:0] cmd_value = '0, cmd_max = '0;
    logic       cmd_ready, cnt_load, cnt_enable, cnt_up_down, busy, done, aborted;
    logic [7:0] cnt_load_val, cnt_max;
    logic [7:0] count;
`ifdef PCC_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks = 0, failures = 0;
    int done_at, done_cnt, ab_at, ab_cnt, bad_en;
    logic       en_at_ab;
    logic [7:0] cnt_tr [0:31];
    logic       rdy_tr [0:31];

    always #5 clk = ~clk;

    // Environment counter: load has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (cnt_load)
            count <= cnt_load_val;
        else if (cnt_enable)
            count <= cnt_up_down ? count + 8'd1 : count - 8'd1;
    end

    prog_counter_ctrl #(.W(8), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_value   (cmd_value),
        .cmd_max     (cmd_max),
        .cmd_up      (cmd_up),
        .pause       (pause),
        .abort       (abort),
        .cnt_tc      (count == cnt_max),
        .cnt_zero    (count == 8'd0),
`ifdef PCC_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .cnt_load    (cnt_load),
        .cnt_enable  (cnt_enable),
        .cnt_up_down (cnt_up_down),
        .cnt_load_val(cnt_load_val),
        .cnt_max     (cnt_max),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    // Presents one command for one edge; leaves the bench at the negedge of accept+1.
    task automatic issue(input logic [7:0] v, input logic [7:0] m, input logic u, input logic ab);
        @(negedge clk);
        cmd_value = v;
        cmd_max   = m;
        cmd_up    = u;
        cmd_valid = 1'b1;
        abort     = ab;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
    endtask

    // Observes n cycles (offset k = k-th cycle after accept), driving pause/abort on the way.
    task automatic window(input int n, input int p_from, input int p_to, input int ab_k);
        done_at = -1; done_cnt = 0; ab_at = -1; ab_cnt = 0; bad_en = 0; en_at_ab = 1'b0;
        for (int k = 1; k <= n; k++) begin
            pause = (k >= p_from && k < p_to);
            abort = (k == ab_k);
            #1;
            cnt_tr[k] = count;
            rdy_tr[k] = cmd_ready;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (aborted === 1'b1) begin
                ab_cnt++;
                if (ab_at < 0) ab_at = k;
            end
            if (cnt_enable === 1'b1 && (cnt_up_down ? count == cnt_max : count == 8'd0)) bad_en++;
            if (k == ab_k) en_at_ab = cnt_load | cnt_enable;
            @(negedge clk);
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, cnt_load, cnt_enable, cnt_up_down, done, aborted} !== 7'b0 ||
            cnt_load_val !== 8'd0 || cnt_max !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b ld=%b en=%b ud=%b done=%b ab=%b lv=%0d mx=%0d, want all 0",
                     cmd_ready, busy, cnt_load, cnt_enable, cnt_up_down, done, aborted, cnt_load_val, cnt_max);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b busy=%b, want rdy=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_up;
        issue(8'd5, 8'd10, 1'b1, 1'b0);
        checks++;
        if (cnt_load !== 1'b1 || cnt_enable !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL up_load_cycle: got ld=%b en=%b rdy=%b busy=%b, want 1 0 0 1", cnt_load, cnt_enable, cmd_ready, busy);
        end
        checks++;
        if (cnt_load_val !== 8'd5 || cnt_max !== 8'd10 || cnt_up_down !== 1'b1) begin
            failures++;
            $display("FAIL up_regs: got lv=%0d mx=%0d ud=%b, want 5 10 1", cnt_load_val, cnt_max, cnt_up_down);
        end
        window(12, 0, 0, 0);
        checks++;
        if (done_at !== 8 || done_cnt !== 1) begin
            failures++;
            $display("FAIL up_done: got at=%0d pulses=%0d, want at=8 pulses=1", done_at, done_cnt);
        end
        checks++;
        if (cnt_tr[2] !== 8'd5 || cnt_tr[8] !== 8'd10 || cnt_tr[12] !== 8'd10 || bad_en !== 0) begin
            failures++;
            $display("FAIL up_count: got c2=%0d c8=%0d c12=%0d overstep=%0d, want 5 10 10 0",
                     cnt_tr[2], cnt_tr[8], cnt_tr[12], bad_en);
        end
        checks++;
        if (rdy_tr[9] !== 1'b1 || rdy_tr[7] !== 1'b0) begin
            failures++;
            $display("FAIL up_ready: got r7=%b r9=%b, want 0 1", rdy_tr[7], rdy_tr[9]);
        end
    endtask

    task automatic test_down;
        issue(8'd3, 8'd0, 1'b0, 1'b0);
        window(10, 0, 0, 0);
        checks++;
        if (done_at !== 6 || done_cnt !== 1) begin
            failures++;
            $display("FAIL down_done: got at=%0d pulses=%0d, want at=6 pulses=1", done_at, done_cnt);
        end
        checks++;
        if (cnt_tr[2] !== 8'd3 || cnt_tr[4] !== 8'd1 || cnt_tr[10] !== 8'd0 || bad_en !== 0) begin
            failures++;
            $display("FAIL down_count: got c2=%0d c4=%0d c10=%0d en_at_zero=%0d, want 3 1 0 0",
                     cnt_tr[2], cnt_tr[4], cnt_tr[10], bad_en);
        end
    endtask

    task automatic test_pause;
        issue(8'd0, 8'd4, 1'b1, 1'b0);
        window(14, 3, 6, 0);
        checks++;
        if (cnt_tr[3] !== 8'd1 || cnt_tr[4] !== 8'd1 || cnt_tr[6] !== 8'd1 || cnt_tr[7] !== 8'd2) begin
            failures++;
            $display("FAIL pause_freeze: got c3=%0d c4=%0d c6=%0d c7=%0d, want 1 1 1 2",
                     cnt_tr[3], cnt_tr[4], cnt_tr[6], cnt_tr[7]);
        end
        checks++;
        if (done_at !== 10 || done_cnt !== 1 || cnt_tr[14] !== 8'd4) begin
            failures++;
            $display("FAIL pause_done: got at=%0d pulses=%0d final=%0d, want 10 1 4", done_at, done_cnt, cnt_tr[14]);
        end
    endtask

    task automatic test_abort_run;
        issue(8'd2, 8'd9, 1'b1, 1'b0);
        window(12, 0, 0, 7);
        checks++;
        if (en_at_ab !== 1'b0) begin
            failures++;
            $display("FAIL abort_run_quiet: got load|enable=%b in abort cycle, want 0", en_at_ab);
        end
        checks++;
        if (ab_at !== 8 || ab_cnt !== 1 || done_cnt !== 0) begin
            failures++;
            $display("FAIL abort_run_pulse: got ab_at=%0d ab_cnt=%0d done_cnt=%0d, want 8 1 0", ab_at, ab_cnt, done_cnt);
        end
        checks++;
        if (cnt_tr[7] !== 8'd7 || cnt_tr[12] !== 8'd7 || rdy_tr[8] !== 1'b1) begin
            failures++;
            $display("FAIL abort_run_hold: got c7=%0d c12=%0d rdy8=%b, want 7 7 1", cnt_tr[7], cnt_tr[12], rdy_tr[8]);
        end
    endtask

    task automatic test_abort_edges;
        issue(8'd1, 8'd3, 1'b1, 1'b1);
        window(8, 0, 0, 0);
        checks++;
        if (done_at !== 5 || ab_cnt !== 0 || cnt_tr[8] !== 8'd3) begin
            failures++;
            $display("FAIL abort_idle_accept: got done_at=%0d ab_cnt=%0d final=%0d, want 5 0 3", done_at, ab_cnt, cnt_tr[8]);
        end
        issue(8'd2, 8'd0, 1'b0, 1'b0);
        window(8, 0, 0, 5);
        checks++;
        if (done_at !== 5 || done_cnt !== 1 || ab_cnt !== 0) begin
            failures++;
            $display("FAIL abort_in_done: got done_at=%0d done_cnt=%0d ab_cnt=%0d, want 5 1 0", done_at, done_cnt, ab_cnt);
        end
        issue(8'd4, 8'd9, 1'b1, 1'b0);
        window(6, 0, 0, 1);
        checks++;
        if (en_at_ab !== 1'b0 || ab_at !== 2 || done_cnt !== 0 || cnt_tr[4] !== 8'd0) begin
            failures++;
            $display("FAIL abort_in_load: got ld|en=%b ab_at=%0d done_cnt=%0d c4=%0d, want 0 2 0 0",
                     en_at_ab, ab_at, done_cnt, cnt_tr[4]);
        end
    endtask

    task automatic test_degenerate_and_reset;
        issue(8'd6, 8'd6, 1'b1, 1'b0);
        window(6, 0, 0, 0);
        checks++;
        if (done_at !== 3 || done_cnt !== 1 || cnt_tr[2] !== 8'd6 || cnt_tr[6] !== 8'd6 || bad_en !== 0) begin
            failures++;
            $display("FAIL degenerate: got done_at=%0d pulses=%0d c2=%0d c6=%0d overstep=%0d, want 3 1 6 6 0",
                     done_at, done_cnt, cnt_tr[2], cnt_tr[6], bad_en);
        end
        issue(8'd0, 8'd50, 1'b1, 1'b0);
        window(4, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, cnt_load, cnt_enable, cnt_up_down, done, aborted} !== 7'b0 ||
            cnt_load_val !== 8'd0 || cnt_max !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got rdy=%b busy=%b ld=%b en=%b ud=%b done=%b ab=%b lv=%0d mx=%0d, want all 0",
                     cmd_ready, busy, cnt_load, cnt_enable, cnt_up_down, done, aborted, cnt_load_val, cnt_max);
        end
        rst_n = 1'b1;
        window(6, 0, 0, 0);
        checks++;
        if (done_cnt !== 0 || ab_cnt !== 0 || rdy_tr[1] !== 1'b1 || cnt_tr[6] !== 8'd0) begin
            failures++;
            $display("FAIL reset_silent: got done_cnt=%0d ab_cnt=%0d rdy=%b count=%0d, want 0 0 1 0",
                     done_cnt, ab_cnt, rdy_tr[1], cnt_tr[6]);
        end
    endtask

`ifdef PCC_TIMEOUT_EN
    task automatic test_timeout;
        issue(8'd0, 8'd20, 1'b1, 1'b0);
        window(8, 0, 0, 0);
        checks++;
        if (ab_at !== 6 || ab_cnt !== 1 || done_cnt !== 0 || cnt_tr[8] !== 8'd3 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: got ab_at=%0d ab_cnt=%0d done_cnt=%0d count=%0d err=%b, want 6 1 0 3 1",
                     ab_at, ab_cnt, done_cnt, cnt_tr[8], timeout_err);
        end
        issue(8'd0, 8'd1, 1'b1, 1'b0);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got err=%b, want 0", timeout_err);
        end
        window(6, 0, 0, 0);
    endtask
`endif

    initial begin
        test_reset;
        test_up;
        test_down;
        test_pause;
        test_abort_run;
        test_abort_edges;
        test_degenerate_and_reset;
`ifdef PCC_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
